// File: rtl/id_pipe.sv
// Instruction-decode pipeline stage: decodes RV32I-style instructions, reads operands,
// detects load-use hazards and presents a registered valid/ready output slot.
module id_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_wen_o,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              illegal_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic              reg_wen;
        logic              is_load;
        logic              is_store;
        logic              illegal;
    } dec_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   imm_j;
    logic              use_rs1;
    logic              use_rs2;
    logic              wen;
    logic              stall;
    logic              in_fire;
    dec_t              dec;
    dec_t              data_d;
    dec_t              data_q;
    logic              valid_d;
    logic              valid_q;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rd_f   = REG_AW'(inst_i[11:7]);
    assign rs1_f  = REG_AW'(inst_i[19:15]);
    assign rs2_f  = REG_AW'(inst_i[24:20]);

    assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'h000}));
    assign imm_j = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Format decode; source usage follows the opcode even when funct3 is unsupported.
    always_comb begin
        dec      = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        wen      = 1'b0;
        dec.inst = inst_i;
        dec.addr = inst_addr_i;
        case (opcode)
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                dec.op1 = rs1_data_i;
                dec.op2 = imm_i;
                dec.imm = imm_i;
                dec.rd  = rd_f;
                wen     = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.op1 = rs1_data_i;
                dec.op2 = rs2_data_i;
                dec.rd  = rd_f;
                wen     = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.op1 = rs1_data_i;
                    dec.op2 = rs2_data_i;
                    dec.imm = imm_b;
                end
            end
            OPC_JAL: begin
                dec.op1 = inst_addr_i;
                dec.op2 = imm_j;
                dec.imm = imm_j;
                dec.rd  = rd_f;
                wen     = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                if (funct3 != 3'b000) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.op1 = rs1_data_i;
                    dec.op2 = imm_i;
                    dec.imm = imm_i;
                    dec.rd  = rd_f;
                    wen     = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.op2 = imm_u;
                dec.imm = imm_u;
                dec.rd  = rd_f;
                wen     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op1 = inst_addr_i;
                dec.op2 = imm_u;
                dec.imm = imm_u;
                dec.rd  = rd_f;
                wen     = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.op1     = rs1_data_i;
                    dec.op2     = imm_i;
                    dec.imm     = imm_i;
                    dec.rd      = rd_f;
                    dec.is_load = 1'b1;
                    wen         = 1'b1;
                end
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct3 > 3'b010) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.op1      = rs1_data_i;
                    dec.op2      = rs2_data_i;
                    dec.imm      = imm_s;
                    dec.is_store = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.reg_wen = wen && (dec.rd != '0);
    end

    assign rs1_addr_o = use_rs1 ? rs1_f : '0;
    assign rs2_addr_o = use_rs2 ? rs2_f : '0;

    // Load-use hazard against the instruction currently in EX.
    assign stall = in_valid && ex_is_load_i && (ex_rd_i != '0) &&
                   ((use_rs1 && (rs1_f == ex_rd_i)) || (use_rs2 && (rs2_f == ex_rd_i)));

    assign in_ready = (!valid_q || out_ready) && !stall;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d = 1'b1;
            data_d  = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid   = valid_q;
    assign inst_o      = data_q.inst;
    assign inst_addr_o = data_q.addr;
    assign op1_o       = data_q.op1;
    assign op2_o       = data_q.op2;
    assign imm_o       = data_q.imm;
    assign rd_addr_o   = data_q.rd;
    assign reg_wen_o   = data_q.reg_wen;
    assign is_load_o   = data_q.is_load;
    assign is_store_o  = data_q.is_store;
    assign illegal_o   = data_q.illegal;

endmodule
